// File: rtl/tape_mem.sv
// Data-tape memory responder: zero-fills the tape after reset, then serves one load
// and one store per cycle from NCORES requesters with a fixed 2-cycle load latency.
module tape_mem #(
  parameter int NCORES = 4,
  parameter int DEPTH  = 4096,
  parameter int WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCORES-1:0]       ld_en,
  input  logic [NCORES*16-1:0]    ld_addr,
  input  logic [NCORES-1:0]       st_en,
  input  logic [NCORES*16-1:0]    st_addr,
  input  logic [NCORES*WIDTH-1:0] st_data,
  output logic [WIDTH-1:0]        ld_data,
  output logic                    ld_valid,
  output logic                    ready,
  output logic                    err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;

  logic             ld_sel;
  logic [15:0]      ld_sel_addr;
  logic             st_sel;
  logic [15:0]      st_sel_addr;
  logic [WIDTH-1:0] st_sel_data;

  logic             ld_multi;
  logic             st_multi;
  logic             ld_oor;
  logic             st_oor;
  logic             active;
  logic             st_do;
  logic             ld_do;
  logic [AW-1:0]    ld_idx;
  logic [AW-1:0]    st_idx;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] ld_word;

  // Descending scan so the lowest-index requester is the last assignment and wins.
  always_comb begin
    ld_sel      = 1'b0;
    ld_sel_addr = '0;
    st_sel      = 1'b0;
    st_sel_addr = '0;
    st_sel_data = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (ld_en[i]) begin
        ld_sel      = 1'b1;
        ld_sel_addr = ld_addr[i*16 +: 16];
      end
      if (st_en[i]) begin
        st_sel      = 1'b1;
        st_sel_addr = st_addr[i*16 +: 16];
        st_sel_data = st_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ld_multi = (ld_en & (ld_en - NCORES'(1))) != '0;
    st_multi = (st_en & (st_en - NCORES'(1))) != '0;
    ld_oor   = {1'b0, ld_sel_addr} >= 17'(DEPTH);
    st_oor   = {1'b0, st_sel_addr} >= 17'(DEPTH);
    active   = (state == S_READY);
    st_do    = active && st_sel && !st_oor;
    ld_do    = active && ld_sel;
    ld_idx   = ld_sel_addr[AW-1:0];
    st_idx   = st_sel_addr[AW-1:0];
    // Same-cycle store to the same word is forwarded so the load sees it.
    rd_word  = (st_do && (st_idx == ld_idx)) ? st_sel_data : mem[ld_idx];
    ld_word  = ld_oor ? '0 : rd_word;
  end

  // Array is deliberately unreset; the CLEAR sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else if (st_do) begin
      mem[st_idx] <= st_sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_CLEAR;
      cnt      <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      s1_valid <= 1'b0;
      s1_data  <= '0;
      ld_valid <= 1'b0;
      ld_data  <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(DEPTH - 1)) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        S_READY: begin
          if (ld_multi || st_multi || (ld_sel && ld_oor) || (st_sel && st_oor)) begin
            err <= 1'b1;
          end
        end
        default: state <= S_CLEAR;
      endcase

      s1_valid <= ld_do;
      if (ld_do) begin
        s1_data <= ld_word;
      end
      ld_valid <= s1_valid;
      if (s1_valid) begin
        ld_data <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_tape_mem.sv
// Bench for tape_mem (DEPTH=16): directed steps plus random traffic against an
// array/queue model of the tape, checked with immediate assertions every cycle.
module tb_tape_mem;

  localparam int NC    = 4;
  localparam int DEPTH = 16;
  localparam int W     = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NC-1:0]   ld_en;
  logic [NC*16-1:0] ld_addr;
  logic [NC-1:0]   st_en;
  logic [NC*16-1:0] st_addr;
  logic [NC*W-1:0] st_data;
  logic [W-1:0]    ld_data;
  logic            ld_valid;
  logic            ready;
  logic            err;

  tape_mem #(.NCORES(NC), .DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .st_en   (st_en),
    .st_addr (st_addr),
    .st_data (st_data),
    .ld_data (ld_data),
    .ld_valid(ld_valid),
    .ready   (ready),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] exp_q [$];
  int           due_q [$];
  bit           m_ready;
  int           m_clear;
  bit           m_err;
  logic [W-1:0] last_data;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cur);
    end
  endtask

  function automatic int lowest(logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: stores land before the same-cycle load reads, which covers forwarding.
  task automatic model_step();
    int li, si, a;
    logic [W-1:0] d;
    if (!m_ready) begin
      m_clear++;
      if (m_clear == DEPTH) m_ready = 1'b1;
      return;
    end
    if ($countones(ld_en) > 1 || $countones(st_en) > 1) m_err = 1'b1;
    si = lowest(st_en);
    if (si >= 0) begin
      a = int'(st_addr[si*16 +: 16]);
      if (a >= DEPTH) m_err = 1'b1;
      else ref_mem[a] = st_data[si*W +: W];
    end
    li = lowest(ld_en);
    if (li >= 0) begin
      a = int'(ld_addr[li*16 +: 16]);
      if (a >= DEPTH) begin
        m_err = 1'b1;
        d = '0;
      end else begin
        d = ref_mem[a];
      end
      due_q.push_back(cur + 2);
      exp_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    bit exp_v;
    exp_v = (due_q.size() > 0) && (due_q[0] == cur);
    if (exp_v) begin
      last_data = exp_q[0];
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    check("ld_valid", 32'(ld_valid), 32'(exp_v));
    check("ld_data", 32'(ld_data), 32'(last_data));
    check("ready", 32'(ready), 32'(m_ready));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cur++;
    check_outputs();
  endtask

  task automatic idle();
    ld_en   = '0;
    st_en   = '0;
    ld_addr = '0;
    st_addr = '0;
    st_data = '0;
  endtask

  task automatic ld(int c, int a);
    ld_en[c] = 1'b1;
    ld_addr[c*16 +: 16] = 16'(a);
  endtask

  task automatic st(int c, int a, int d);
    st_en[c] = 1'b1;
    st_addr[c*16 +: 16] = 16'(a);
    st_data[c*W +: W] = W'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    due_q.delete();
    exp_q.delete();
    m_ready   = 1'b0;
    m_clear   = 0;
    m_err     = 1'b0;
    last_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    check("rst_ld_valid", 32'(ld_valid), 32'd0);
    check("rst_ld_data", 32'(ld_data), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    int r;
    idle();
    do_reset();

    // Zero-fill: ready low for DEPTH cycles, then high.
    repeat (DEPTH) tick();

    // Every word reads back zero, one load per cycle.
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      ld(a % NC, a);
      tick();
    end
    idle();
    repeat (3) tick();

    // Store then load on the next cycle.
    st(1, 5, 'h00AB);
    tick();
    idle();
    ld(0, 5);
    tick();
    idle();
    repeat (3) tick();

    // Same-cycle store/load to one address.
    st(2, 7, 'h1234);
    ld(0, 7);
    tick();
    idle();
    repeat (3) tick();

    // Preload, then three back-to-back loads.
    st(0, 1, 'h11); tick(); idle();
    st(0, 2, 'h22); tick(); idle();
    st(0, 3, 'h33); tick(); idle();
    ld(3, 1); tick(); idle();
    ld(3, 2); tick(); idle();
    ld(3, 3); tick(); idle();
    repeat (3) tick();

    // Multi-hot load: core1 wins, err sticks through clean traffic.
    ld(1, 2);
    ld(2, 9);
    tick();
    idle();
    ld(0, 3); tick(); idle();
    st(0, 4, 'h44); tick(); idle();
    repeat (3) tick();

    // Out-of-range store must not alias into any word.
    st(3, DEPTH, 'hBEEF);
    tick();
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      ld(a % NC, a);
      tick();
      idle();
    end
    repeat (3) tick();

    // Random traffic, including multi-hot requests and out-of-range addresses.
    repeat (300) begin
      idle();
      r = $urandom_range(0, 9);
      if (r < NC) ld(r, $urandom_range(0, DEPTH + 1));
      else if (r == NC) begin
        ld_en = NC'($urandom_range(0, (1 << NC) - 1));
        for (int c = 0; c < NC; c++) ld_addr[c*16 +: 16] = 16'($urandom_range(0, DEPTH + 1));
      end
      r = $urandom_range(0, 9);
      if (r < NC) st(r, $urandom_range(0, DEPTH + 1), $urandom_range(0, 65535));
      else if (r == NC) begin
        st_en = NC'($urandom_range(0, (1 << NC) - 1));
        for (int c = 0; c < NC; c++) begin
          st_addr[c*16 +: 16] = 16'($urandom_range(0, DEPTH - 1));
          st_data[c*W +: W]   = W'($urandom_range(0, 65535));
        end
      end
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset one cycle after a load: that load never completes, sweep restarts.
    st(0, 5, 'h5A5A);
    tick();
    idle();
    ld(0, 5);
    tick();
    idle();
    do_reset();
    repeat (DEPTH + 3) tick();
    ld(2, 5);
    tick();
    idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tape_mem.md
Name: tape_mem

Overview:
- Data-tape memory responder at the far end of the per-core select load/store request interface.
- Accepts at most one load and one store per cycle from NCORES requesters.
- Returns load data with a fixed 2-cycle latency, matching the requester's ld_en→ld_en1→ld_en2 pipeline.
- Zero-fills the tape after reset; `ready` holds the cores until the fill completes.

Parameters:
- NCORES, 4, number of requesting cores (≥1).
- DEPTH, 4096, tape words, a power of two ≤ 65536; the address index is $clog2(DEPTH) bits.
- WIDTH, 16, data word width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ld_en  in  NCORES  per-core load request; expected one-hot or zero.
- ld_addr  in  NCORES*16  per-core load address; core i occupies [i*16 +: 16].
- st_en  in  NCORES  per-core store request; expected one-hot or zero.
- st_addr  in  NCORES*16  per-core store address, same packing as ld_addr.
- st_data  in  NCORES*WIDTH  per-core store data; core i occupies [i*WIDTH +: WIDTH].
- ld_data  out  WIDTH  load result, broadcast to all cores.
- ld_valid  out  1  high in the cycle ld_data carries a result.
- ready  out  1  high once the zero-fill is complete.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: ld_data=0, ld_valid=0, ready=0, err=0; FSM=CLEAR; clear counter=0; both pipeline stages invalid.
- Reset asserted mid-operation aborts all in-flight loads: no ld_valid is produced for them, and the FSM restarts CLEAR from word 0.
- FSM CLEAR:
  - Each cycle, write 0 to mem[cnt] and increment cnt.
  - In the cycle cnt==DEPTH-1 is written, transition to READY.
  - Duration is exactly DEPTH cycles after reset deassertion.
  - ld_en and st_en are ignored and err is not set.
- FSM READY:
  - ready=1; stays in READY until reset.
- Request selection (READY only):
  - The lowest-index set bit of ld_en wins the load; its address is muxed from ld_addr.
  - The lowest-index set bit of st_en wins the store; its address and data are muxed from st_addr and st_data.
  - More than one bit set in ld_en, or more than one in st_en: err<=1. The lowest index is still serviced.
- Address range:
  - Address ≥ DEPTH sets err<=1.
  - An out-of-range store is dropped.
  - An out-of-range load still completes and returns 0.
- Store: accepted in cycle t, written at the posedge ending cycle t.
- Load timing:
  - Load accepted in cycle t → ld_valid=1 and ld_data valid during cycle t+2.
  - Stage 1 registers the read at the end of t; stage 2 registers the output at the end of t+1.
  - Back-to-back loads are fully pipelined: one result per cycle.
- Ordering:
  - The load result reflects all stores accepted in cycles ≤ t.
  - A same-cycle store to the same address is forwarded: the load returns the new st_data, not the old memory word.
  - Stores accepted in t+1 or later are not reflected.
- ld_data holds its last value when ld_valid=0.
- err is cleared only by rst.
- The memory array itself is not reset; only the CLEAR sweep initialises it.

Test Plan:
- Reset, DEPTH=16:
  - ready=0 for 16 cycles after rst deasserts, then 1.
  - Loads of addresses 0..15 each return 0 with ld_valid exactly 2 cycles after ld_en.
- Store core1 addr 5 = 0x00AB at cycle t, then load core0 addr 5 at t+1 → ld_data=0x00AB at t+3, ld_valid=1 only at t+3.
- Same-cycle store core2 addr 7 = 0x1234 and load core0 addr 7 → ld_data=0x1234 two cycles later (forwarded).
- Loads on 3 consecutive cycles, addresses 1,2,3, preloaded with 0x11,0x22,0x33 → ld_valid high for 3 consecutive cycles with data 0x11,0x22,0x33.
- Errors:
  - ld_en=4'b0110 with addresses 2 and 9 → core1's address 2 is serviced and err=1, remaining set after further clean traffic.
  - Store to address 16 (DEPTH=16) → err=1, no word modified.
- Assert rst one cycle after issuing a load → no ld_valid for that load; ready=0 and the CLEAR sweep restarts; err=0.
